// File: rtl/sidnboard2_pkg.sv
// Shared constants, SID register map and state encodings for the sidnboard2 image.
// Register constants name the SID map for host-side tooling and future address checks.
package sidnboard2_pkg;

    localparam int DEF_CLK_FREQ   = 12_000_000;
    localparam int DEF_BAUD       = 115_200;
    localparam int DEF_PHI2_FREQ  = 1_000_000;
    localparam int DEF_RES_CYCLES = 16;

    localparam logic [7:0] FREQ_LO_1   = 8'h00;
    localparam logic [7:0] FREQ_HI_1   = 8'h01;
    localparam logic [7:0] CTRL_1      = 8'h04;
    localparam logic [7:0] AD_1        = 8'h05;
    localparam logic [7:0] SR_1        = 8'h06;
    localparam logic [7:0] MODE_VOL    = 8'h18;
    localparam logic [7:0] MAX_WR_ADDR = 8'h18;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic {
        PAIR_ADDR,
        PAIR_DATA
    } pair_state_t;

    function automatic logic addr_ok(input logic [7:0] addr);
        return (addr[7:5] == 3'b000) && (addr <= MAX_WR_ADDR);
    endfunction

endpackage

// File: rtl/sid_n_board2_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, glitch rejection on start bit.
//
// state    | meaning
// RX_IDLE  | line high, waiting for a low level
// RX_START | half-bit wait, then confirm start bit still low
// RX_DATA  | eight data samples, LSB first, one bit time apart
// RX_STOP  | stop sample: 1 -> byte_valid, 0 -> frame_err
module uart_rx
    import sidnboard2_pkg::*;
#(
    parameter int BAUD_DIV = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int             CW   = 16;
    localparam logic [CW-1:0]  FULL = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0]  HALF = CW'(BAUD_DIV / 2 - 1);

    logic          rx_meta, rx_s;
    rx_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_cnt, bit_nxt;
    logic [7:0]    shreg, sh_nxt;
    logic          valid_nxt, err_nxt;

    assign data = shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_s       <= rx_meta;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_cnt    <= bit_nxt;
            shreg      <= sh_nxt;
            byte_valid <= valid_nxt;
            frame_err  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_cnt;
        sh_nxt    = shreg;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_nxt = RX_START;
                    cnt_nxt   = HALF;
                end
            end
            RX_START: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (rx_s) begin
                    state_nxt = RX_IDLE;
                end else begin
                    state_nxt = RX_DATA;
                    cnt_nxt   = FULL;
                    bit_nxt   = '0;
                end
            end
            RX_DATA: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    sh_nxt  = {rx_s, shreg[7:1]};
                    cnt_nxt = FULL;
                    if (bit_cnt == 3'd7) state_nxt = RX_STOP;
                    else                 bit_nxt   = bit_cnt + 3'd1;
                end
            end
            RX_STOP: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    // Back to idle right at the stop sample so a following frame is not missed.
                    state_nxt = RX_IDLE;
                    if (rx_s) valid_nxt = 1'b1;
                    else      err_nxt   = 1'b1;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/sid_n_board2.sv
// Host UART to SID bridge: pairs bytes into register writes and drives phi2, reset and bus cycles.
//
// state     | meaning
// PAIR_ADDR | next valid byte is a register address
// PAIR_DATA | next valid byte completes the pair as data
module sid_n_board2
    import sidnboard2_pkg::*;
#(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int BAUD       = DEF_BAUD,
    parameter int PHI2_FREQ  = DEF_PHI2_FREQ,
    parameter int RES_CYCLES = DEF_RES_CYCLES
) (
    input  logic       CLK_IN,
    input  logic       RST_i,
    input  logic       RS232_RX_i,
    output logic       SID_PHI2_o,
    output logic       SID_RES_N_o,
    output logic       SID_CS_N_o,
    output logic       SID_RW_o,
    output logic [4:0] SID_A_o,
    output logic [7:0] SID_D_o
);

    localparam int BAUD_DIV  = CLK_FREQ / BAUD;
    localparam int PHI2_DIV  = CLK_FREQ / PHI2_FREQ;
    localparam int PW        = $clog2(PHI2_DIV);
    localparam int RW        = $clog2(RES_CYCLES + 1);

    localparam logic [PW-1:0] PHI2_LAST  = PW'(PHI2_DIV - 1);
    localparam logic [PW-1:0] PHI2_HALF  = PW'(PHI2_DIV / 2);
    localparam logic [PW-1:0] PHI2_PRERISE = PW'(PHI2_DIV / 2 - 1);
    localparam logic [RW-1:0] RES_INIT   = RW'(RES_CYCLES);

    logic [7:0]  rx_data;
    logic        byte_valid, frame_err;

    pair_state_t pair_state, pair_nxt;
    logic        pair_done;
    logic [7:0]  addr_q;
    logic [4:0]  hold_a;
    logic [7:0]  hold_d;
    logic        pending, writing;

    logic [PW-1:0] phi_cnt;
    logic          phi_last;
    logic [RW-1:0] res_left;

    uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk        (CLK_IN),
        .rst        (RST_i),
        .rx         (RS232_RX_i),
        .data       (rx_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    always_comb begin
        pair_nxt  = pair_state;
        pair_done = 1'b0;
        if (frame_err) begin
            pair_nxt = PAIR_ADDR;
        end else if (byte_valid) begin
            case (pair_state)
                PAIR_ADDR: pair_nxt = PAIR_DATA;
                PAIR_DATA: begin
                    pair_nxt  = PAIR_ADDR;
                    pair_done = addr_ok(addr_q);
                end
                default: pair_nxt = PAIR_ADDR;
            endcase
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RST_i) begin
            pair_state <= PAIR_ADDR;
            addr_q     <= '0;
            hold_a     <= '0;
            hold_d     <= '0;
        end else begin
            pair_state <= pair_nxt;
            if (byte_valid && pair_state == PAIR_ADDR) addr_q <= rx_data;
            if (pair_done) begin
                hold_a <= addr_q[4:0];
                hold_d <= rx_data;
            end
        end
    end

    assign phi_last    = (phi_cnt == PHI2_LAST);
    assign SID_PHI2_o  = (phi_cnt >= PHI2_HALF);
    assign SID_RES_N_o = (res_left == '0);

    always_ff @(posedge CLK_IN) begin
        if (RST_i) begin
            phi_cnt  <= '0;
            res_left <= RES_INIT;
        end else begin
            phi_cnt <= phi_last ? '0 : phi_cnt + 1'b1;
            // Counted on the edge that takes phi2 high.
            if (phi_cnt == PHI2_PRERISE && res_left != '0) res_left <= res_left - 1'b1;
        end
    end

    // Bus cycles start and end on the clock that wraps phi_cnt to 0 (phi2 falling edge).
    always_ff @(posedge CLK_IN) begin
        if (RST_i) begin
            SID_CS_N_o <= 1'b1;
            SID_RW_o   <= 1'b1;
            SID_A_o    <= '0;
            SID_D_o    <= '0;
            writing    <= 1'b0;
            pending    <= 1'b0;
        end else begin
            if (phi_last) begin
                if (writing) begin
                    writing    <= 1'b0;
                    SID_CS_N_o <= 1'b1;
                    SID_RW_o   <= 1'b1;
                end else if (pending && SID_RES_N_o) begin
                    writing    <= 1'b1;
                    SID_CS_N_o <= 1'b0;
                    SID_RW_o   <= 1'b0;
                    SID_A_o    <= hold_a;
                    SID_D_o    <= hold_d;
                end
            end
            if (pair_done)                pending <= 1'b1;
            else if (phi_last && writing) pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sid_n_board2.sv
// Directed bench for sid_n_board2: UART frames in, observed SID write cycles checked against hand values.
module tb_sid_n_board2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       sid_phi2, sid_res_n, sid_cs_n, sid_rw;
    logic [4:0] sid_a;
    logic [7:0] sid_d;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
        int         len;
        bit         aligned;
        bit         rw_ok;
    } wr_t;

    wr_t  wq[$];
    wr_t  cur;
    bit   in_wr    = 1'b0;
    logic prev_phi = 1'b0;

    sid_n_board2 dut (
        .CLK_IN      (clk),
        .RST_i       (rst),
        .RS232_RX_i  (rx),
        .SID_PHI2_o  (sid_phi2),
        .SID_RES_N_o (sid_res_n),
        .SID_CS_N_o  (sid_cs_n),
        .SID_RW_o    (sid_rw),
        .SID_A_o     (sid_a),
        .SID_D_o     (sid_d)
    );

    always #42ns clk = ~clk;

    initial begin
        #6ms;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
        $fatal(1, "watchdog");
    end

    // Collects every CS_N low window as one write record.
    always @(negedge clk) begin
        if (sid_cs_n === 1'b0) begin
            if (!in_wr) begin
                in_wr       = 1'b1;
                cur.a       = sid_a;
                cur.d       = sid_d;
                cur.len     = 0;
                cur.aligned = (sid_phi2 === 1'b0) && (prev_phi === 1'b1);
                cur.rw_ok   = 1'b1;
            end
            cur.len = cur.len + 1;
            if (sid_rw !== 1'b0 || sid_a !== cur.a || sid_d !== cur.d) cur.rw_ok = 1'b0;
        end else if (in_wr) begin
            in_wr = 1'b0;
            wq.push_back(cur);
        end
        prev_phi = sid_phi2;
    end

    task automatic send_frame(input logic [7:0] b, input bit good_stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (104) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (104) @(negedge clk);
        end
        if (good_stop) begin
            rx = 1'b1;
            repeat (104) @(negedge clk);
        end else begin
            rx = 1'b0;
            repeat (60) @(negedge clk);
            rx = 1'b1;
            repeat (148) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int rises = 0;
        int hi = 0;
        int lo = 0;
        logic p = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (sid_phi2 !== 1'b0) $display("FAIL rst_phi2 got %b want 0", sid_phi2); else passed++;
        checks++; if (sid_res_n !== 1'b0) $display("FAIL rst_res_n got %b want 0", sid_res_n); else passed++;
        checks++; if (sid_cs_n !== 1'b1) $display("FAIL rst_cs_n got %b want 1", sid_cs_n); else passed++;
        checks++; if (sid_rw !== 1'b1) $display("FAIL rst_rw got %b want 1", sid_rw); else passed++;
        checks++; if (sid_a !== 5'h00) $display("FAIL rst_a got %h want 00", sid_a); else passed++;
        checks++; if (sid_d !== 8'h00) $display("FAIL rst_d got %h want 00", sid_d); else passed++;
        wq.delete();
        rst = 1'b0;
        for (int cyc = 0; cyc < 400 && rises < 16; cyc++) begin
            @(negedge clk);
            if (sid_phi2 === 1'b1 && p === 1'b0) begin
                rises++;
                if (rises == 4) begin
                    checks++; if (hi != 6) $display("FAIL phi2_high got %0d want 6", hi); else passed++;
                    checks++; if (lo != 6) $display("FAIL phi2_low got %0d want 6", lo); else passed++;
                end
                if (rises == 15) begin
                    checks++; if (sid_res_n !== 1'b0) $display("FAIL res_n_edge15 got %b want 0", sid_res_n); else passed++;
                end
                if (rises == 16) begin
                    checks++; if (sid_res_n !== 1'b1) $display("FAIL res_n_edge16 got %b want 1", sid_res_n); else passed++;
                end
                hi = 0;
                lo = 0;
            end
            if (sid_phi2 === 1'b1) hi++; else lo++;
            p = sid_phi2;
        end
        checks++; if (rises < 16) $display("FAIL phi2_rises got %0d want 16", rises); else passed++;
        repeat (50) @(negedge clk);
        checks++; if (wq.size() != 0) $display("FAIL idle_no_write got %0d writes want 0", wq.size()); else passed++;
    endtask

    task automatic test_single_write;
        wq.delete();
        send_frame(8'h18, 1'b1);
        send_frame(8'h0F, 1'b1);
        repeat (150) @(negedge clk);
        checks++; if (wq.size() != 1) $display("FAIL single_count got %0d want 1", wq.size()); else passed++;
        if (wq.size() >= 1) begin
            checks++; if (wq[0].a !== 5'h18) $display("FAIL single_a got %h want 18", wq[0].a); else passed++;
            checks++; if (wq[0].d !== 8'h0F) $display("FAIL single_d got %h want 0f", wq[0].d); else passed++;
            checks++; if (wq[0].len != 12) $display("FAIL single_len got %0d want 12", wq[0].len); else passed++;
            checks++; if (!wq[0].aligned) $display("FAIL single_align got 0 want 1"); else passed++;
            checks++; if (!wq[0].rw_ok) $display("FAIL single_bus_stable got 0 want 1"); else passed++;
        end
        checks++; if (sid_cs_n !== 1'b1 || sid_rw !== 1'b1) $display("FAIL single_idle cs=%b rw=%b want 1 1", sid_cs_n, sid_rw); else passed++;
        checks++; if (sid_a !== 5'h18 || sid_d !== 8'h0F) $display("FAIL single_hold a=%h d=%h want 18 0f", sid_a, sid_d); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] ea[5];
        logic [7:0] ed[5];
        ea = '{8'h00, 8'h01, 8'h05, 8'h06, 8'h04};
        ed = '{8'hD0, 8'h07, 8'h55, 8'hF5, 8'h11};
        wq.delete();
        for (int p = 0; p < 5; p++) begin
            send_frame(ea[p], 1'b1);
            send_frame(ed[p], 1'b1);
            case (p)
                0: #13ns;
                1: #500ns;
                2: #2000ns;
                3: #4656ns;
                default: ;
            endcase
        end
        repeat (150) @(negedge clk);
        checks++; if (wq.size() != 5) $display("FAIL b2b_count got %0d want 5", wq.size()); else passed++;
        for (int p = 0; p < 5 && p < wq.size(); p++) begin
            checks++; if (wq[p].a !== ea[p][4:0]) $display("FAIL b2b_a[%0d] got %h want %h", p, wq[p].a, ea[p][4:0]); else passed++;
            checks++; if (wq[p].d !== ed[p]) $display("FAIL b2b_d[%0d] got %h want %h", p, wq[p].d, ed[p]); else passed++;
            checks++; if (wq[p].len != 12) $display("FAIL b2b_len[%0d] got %0d want 12", p, wq[p].len); else passed++;
        end
    endtask

    task automatic test_bad_addr;
        wq.delete();
        send_frame(8'h1F, 1'b1);
        send_frame(8'h55, 1'b1);
        send_frame(8'h04, 1'b1);
        send_frame(8'h11, 1'b1);
        repeat (150) @(negedge clk);
        checks++; if (wq.size() != 1) $display("FAIL badaddr_count got %0d want 1", wq.size()); else passed++;
        if (wq.size() >= 1) begin
            checks++; if (wq[0].a !== 5'h04 || wq[0].d !== 8'h11) $display("FAIL badaddr_pair got %h/%h want 04/11", wq[0].a, wq[0].d); else passed++;
        end
    endtask

    task automatic test_frame_err;
        wq.delete();
        send_frame(8'h18, 1'b1);
        send_frame(8'h33, 1'b0);
        send_frame(8'h06, 1'b1);
        send_frame(8'hF5, 1'b1);
        repeat (150) @(negedge clk);
        checks++; if (wq.size() != 1) $display("FAIL framerr_count got %0d want 1", wq.size()); else passed++;
        if (wq.size() >= 1) begin
            checks++; if (wq[0].a !== 5'h06 || wq[0].d !== 8'hF5) $display("FAIL framerr_pair got %h/%h want 06/f5", wq[0].a, wq[0].d); else passed++;
        end
    endtask

    task automatic test_glitch;
        wq.delete();
        @(negedge clk);
        rx = 1'b0;
        repeat (30) @(negedge clk);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        send_frame(8'h01, 1'b1);
        send_frame(8'h07, 1'b1);
        repeat (150) @(negedge clk);
        checks++; if (wq.size() != 1) $display("FAIL glitch_count got %0d want 1", wq.size()); else passed++;
        if (wq.size() >= 1) begin
            checks++; if (wq[0].a !== 5'h01 || wq[0].d !== 8'h07) $display("FAIL glitch_pair got %h/%h want 01/07", wq[0].a, wq[0].d); else passed++;
        end
    endtask

    task automatic test_reset_midframe;
        wq.delete();
        send_frame(8'h05, 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rx = 1'b1;
        checks++; if (sid_res_n !== 1'b0 || sid_cs_n !== 1'b1) $display("FAIL midrst_outputs res_n=%b cs_n=%b want 0 1", sid_res_n, sid_cs_n); else passed++;
        rst = 1'b0;
        repeat (400) @(negedge clk);
        send_frame(8'h04, 1'b1);
        send_frame(8'h11, 1'b1);
        repeat (150) @(negedge clk);
        checks++; if (wq.size() != 1) $display("FAIL midrst_count got %0d want 1", wq.size()); else passed++;
        if (wq.size() >= 1) begin
            checks++; if (wq[0].a !== 5'h04 || wq[0].d !== 8'h11) $display("FAIL midrst_pair got %h/%h want 04/11", wq[0].a, wq[0].d); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_bad_addr();
        test_frame_err();
        test_glitch();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sid_n_board2.md
# sid_n_board2

Board-level bridge between a host serial link and an external MOS 6581/8580 SID sound chip. Receives 8N1 UART bytes on `RS232_RX_i`, groups them into (register address, data) pairs and turns each pair into one SID bus write cycle. It also generates the SID's 1 MHz φ2 clock and its reset. It is the top of the `sidnboard2` FPGA image, clocked by the 12 MHz board oscillator.

## Interface
- `CLK_FREQ`, 12_000_000: input clock frequency in Hz.
- `BAUD`, 115_200: UART bit rate. `BAUD_DIV = CLK_FREQ/BAUD` (integer division) = 104.
- `PHI2_FREQ`, 1_000_000: SID φ2 frequency. `PHI2_DIV = CLK_FREQ/PHI2_FREQ` = 12; must be even.
- `RES_CYCLES`, 16: φ2 cycles that `SID_RES_N_o` stays low after reset.

Ports:
- `CLK_IN` input, 1 bit: the design's single clock. All logic is on its rising edge.
- `RST_i` input, 1 bit: synchronous, active-high reset. Tie low if unused.
- `RS232_RX_i` input, 1 bit: UART receive line. Asynchronous; idles high.
- `SID_PHI2_o` output, 1 bit: SID φ2 clock.
- `SID_RES_N_o` output, 1 bit: SID reset, active low.
- `SID_CS_N_o` output, 1 bit: SID chip select, active low.
- `SID_RW_o` output, 1 bit: SID read/write; 0 means write.
- `SID_A_o` output, 5 bits: SID register address.
- `SID_D_o` output, 8 bits: SID data bus. Output only; the design never reads the SID.

## Operation
**Reset values:** `SID_PHI2_o`=0, `SID_RES_N_o`=0, `SID_CS_N_o`=1, `SID_RW_o`=1, `SID_A_o`=0, `SID_D_o`=0. The pair state returns to ADDR and any pending write is cleared.

**UART receiver**
- `RS232_RX_i` passes through a 2-flop synchronizer.
- States: IDLE, START, DATA, STOP.
- IDLE→START on a sampled low level.
- In START, the line is re-checked after `BAUD_DIV/2` clocks. If it is high, the event is a glitch and the receiver returns to IDLE.
- DATA takes 8 samples, LSB first, spaced `BAUD_DIV` clocks apart.
- STOP samples one more bit. If it is 1, the receiver emits a one-clock `byte_valid` pulse with the byte. If it is 0, it flags a framing error and emits no byte.
- Either way the receiver returns to IDLE immediately, so back-to-back frames are accepted.

**Pair decoder**
- States: ADDR, DATA.
- ADDR: a valid byte is latched as the address and the state moves to DATA.
- DATA: a valid byte is latched as the data, the pair is complete and the state returns to ADDR.
- A framing error in either state discards the partial pair and forces ADDR.
- Address bits [7:5] must be zero and the address must be ≤ 0x18. Otherwise the completed pair is silently dropped and no write is made.
- A valid completed pair sets `pending` and loads the address and data into holding registers.
- If a new pair completes while `pending` is still set, the new pair overwrites the old one. This cannot happen at the nominal baud rate.

**φ2 generator**
- A counter runs 0..`PHI2_DIV`-1 continuously once out of reset.
- `SID_PHI2_o` is low for counts 0..5 and high for counts 6..11, giving a 50 % duty cycle.

**SID reset**
- `SID_RES_N_o` is held low until `RES_CYCLES` φ2 rising edges have occurred after reset release, then goes high.
- No write is issued while `SID_RES_N_o` is low; a pending write waits.

**Bus write**
- Triggered at φ2 count 0 when `pending`=1 and the SID is out of reset.
- From that point, `SID_A_o` and `SID_D_o` take the held values, and `SID_CS_N_o`=0 and `SID_RW_o`=0.
- These are held for one full φ2 period, low phase then high phase.
- At the next count 0, `SID_CS_N_o`=1, `SID_RW_o`=1 and `pending` clears.
- `SID_A_o` and `SID_D_o` keep their last values when idle.

## Timing
- One UART bit = 104 clocks (8.67 µs).
- `byte_valid` fires about 9.5 bit times after the start edge.
- From the second byte's `byte_valid` to CS_N falling: at most `PHI2_DIV`+1 clocks.
- CS_N low time: exactly `PHI2_DIV` clocks, aligned to φ2 falling edges.
- `RST_i` asserted mid-frame or mid-write takes effect on the next clock with the reset values above. A SID write that is cut off this way is not retried.

## Structure
- Package `sidnboard2_pkg` holds:
  - the default clock, baud and φ2 constants;
  - the SID register address constants, including `FREQ_LO_1`=0x00, `FREQ_HI_1`=0x01, `CTRL_1`=0x04, `AD_1`=0x05, `SR_1`=0x06 and `MODE_VOL`=0x18, with `MAX_WR_ADDR`=0x18;
  - the UART and pair state enums.
- One sub-module, `uart_rx`, with ports: clock, reset, `rx`, `data[7:0]`, `byte_valid`, `frame_err`.
- The pair decoder, φ2 generator, SID reset and bus write logic live in the top.

## Test plan
- Reset released, line idle → φ2 toggles at 1 MHz with 50 % duty; `SID_RES_N_o` rises after 16 φ2 rising edges; CS_N stays 1.
- Send 0x18, 0x0F → exactly one write cycle with A=0x18, D=0x0F, CS_N and RW low for 12 clocks starting at a φ2 falling edge.
- Send pairs (0x00,0xD0), (0x01,0x07), (0x05,0x55), (0x06,0xF5), (0x04,0x11), with gaps between pairs of 13 to 4656 ns → five writes in that order with matching A/D values and none lost.
- Send 0x1F, 0x55, then 0x04, 0x11 → no write for 0x1F; one write A=0x04, D=0x11.
- Send 0x18, then a byte with stop bit 0, then 0x06, 0xF5 → the partial pair is discarded; the only write is A=0x06, D=0xF5.
- A 30-clock low glitch on RX, then a valid pair 0x01, 0x07 → the glitch produces no byte; one write A=0x01, D=0x07.
